// File: rtl/r4_ibutter_seq.sv
// rtl/r4_ibutter_seq.sv - sequential radix-4 inverse butterfly, 4-sample frames in, scaled IDFT out
module r4_ibutter_seq #(
   parameter int W = 4
) (
   input  logic         wb_clk_i,
   input  logic         wb_rst_i,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_re,
   input  logic [W-1:0] in_im,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_re,
   output logic [W-1:0] out_im,
   output logic [1:0]   out_idx,
   output logic         busy,
   output logic [7:0]   frame_cnt
);

   typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DRAIN} state_t;

   state_t       r_state;
   state_t       w_next;
   logic [1:0]   r_lidx;
   logic [1:0]   r_oidx;
   logic         r_oval;
   logic [7:0]   r_fcnt;
   logic [W-1:0] r_x_re [4];
   logic [W-1:0] r_x_im [4];
   logic [W-1:0] r_y_re [4];
   logic [W-1:0] r_y_im [4];

   logic                w_in_xfer;
   logic                w_out_xfer;
   logic                w_last_out;
   logic signed [W+1:0] w_xr [4];
   logic signed [W+1:0] w_xi [4];
   logic signed [W+1:0] w_sr [4];
   logic signed [W+1:0] w_si [4];

   assign w_in_xfer  = (r_state == S_LOAD) && in_valid;
   assign w_out_xfer = (r_state == S_DRAIN) && r_oval && out_ready;
   assign w_last_out = w_out_xfer && (r_oidx == 2'd3);

   always_comb begin
      w_next   = r_state;
      in_ready = 1'b0;
      busy     = 1'b0;
      case (r_state)
         S_LOAD: begin
            in_ready = 1'b1;
            if (w_in_xfer && (r_lidx == 2'd3)) w_next = S_COMPUTE;
         end
         S_COMPUTE: begin
            busy   = 1'b1;
            w_next = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (w_last_out) w_next = S_LOAD;
         end
         default: w_next = S_LOAD;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) r_state <= S_LOAD;
      else          r_state <= w_next;
   end

   // jX = (-Xi, Xr); sums carry two guard bits so the >>>2 result always fits W bits
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_xr[k] = (W+2)'($signed(r_x_re[k]));
         w_xi[k] = (W+2)'($signed(r_x_im[k]));
      end
      w_sr[0] = w_xr[0] + w_xr[1] + w_xr[2] + w_xr[3];
      w_si[0] = w_xi[0] + w_xi[1] + w_xi[2] + w_xi[3];
      w_sr[1] = w_xr[0] - w_xi[1] - w_xr[2] + w_xi[3];
      w_si[1] = w_xi[0] + w_xr[1] - w_xi[2] - w_xr[3];
      w_sr[2] = w_xr[0] - w_xr[1] + w_xr[2] - w_xr[3];
      w_si[2] = w_xi[0] - w_xi[1] + w_xi[2] - w_xi[3];
      w_sr[3] = w_xr[0] + w_xi[1] - w_xr[2] - w_xi[3];
      w_si[3] = w_xi[0] - w_xr[1] - w_xi[2] + w_xr[3];
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_lidx <= 2'd0;
         r_oidx <= 2'd0;
         r_oval <= 1'b0;
         r_fcnt <= 8'd0;
         for (int k = 0; k < 4; k++) begin
            r_x_re[k] <= '0;
            r_x_im[k] <= '0;
            r_y_re[k] <= '0;
            r_y_im[k] <= '0;
         end
      end else begin
         if (w_in_xfer) begin
            r_x_re[r_lidx] <= in_re;
            r_x_im[r_lidx] <= in_im;
            r_lidx         <= r_lidx + 2'd1;
         end
         if (r_state == S_COMPUTE) begin
            for (int k = 0; k < 4; k++) begin
               r_y_re[k] <= W'(w_sr[k] >>> 2);
               r_y_im[k] <= W'(w_si[k] >>> 2);
            end
            r_oidx <= 2'd0;
            r_oval <= 1'b0;
         end
         // first DRAIN cycle only arms the output; r_oval drops again on the y3 transfer
         if ((r_state == S_DRAIN) && !r_oval) r_oval <= 1'b1;
         if (w_out_xfer) begin
            r_oidx <= r_oidx + 2'd1;
            if (r_oidx == 2'd3) begin
               r_oval <= 1'b0;
               r_fcnt <= r_fcnt + 8'd1;
               r_lidx <= 2'd0;
            end
         end
      end
   end

   assign out_valid = r_oval;
   assign out_idx   = r_oidx;
   assign out_re    = r_y_re[r_oidx];
   assign out_im    = r_y_im[r_oidx];
   assign frame_cnt = r_fcnt;

endmodule

// File: tb/tb_r4_ibutter_seq.sv
// tb/tb_r4_ibutter_seq.sv - directed bench for r4_ibutter_seq with hand-computed frames
module tb_r4_ibutter_seq;

   logic       wb_clk_i;
   logic       wb_rst_i;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_re;
   logic [3:0] in_im;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_re;
   logic [3:0] out_im;
   logic [1:0] out_idx;
   logic       busy;
   logic [7:0] frame_cnt;

   int total;
   int bad;

   logic       got_v   [4];
   logic [1:0] got_idx [4];
   logic [3:0] got_re  [4];
   logic [3:0] got_im  [4];

   r4_ibutter_seq #(.W(4)) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_idx   (out_idx),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   // packed frames: bits [4k+3:4k] hold sample k
   task automatic load_frame(input logic [15:0] re, input logic [15:0] im);
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_re    = re[4*k +: 4];
         in_im    = im[4*k +: 4];
         @(posedge wb_clk_i); #1;
      end
      in_valid = 1'b0;
      in_re    = 4'h0;
      in_im    = 4'h0;
   endtask

   task automatic drain(output bit tmo);
      int n;
      tmo       = 1'b0;
      n         = 0;
      out_ready = 1'b1;
      while (!out_valid && n < 20) begin
         @(posedge wb_clk_i); #1;
         n++;
      end
      if (!out_valid) begin
         tmo       = 1'b1;
         out_ready = 1'b0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            got_v[k]   = out_valid;
            got_idx[k] = out_idx;
            got_re[k]  = out_re;
            got_im[k]  = out_im;
            @(posedge wb_clk_i); #1;
         end
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      wb_rst_i  = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_re     = 4'h0;
      in_im     = 4'h0;
      repeat (2) @(posedge wb_clk_i);
      #1;
      wb_rst_i = 1'b0;
      total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if ({out_re, out_im} !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h/%h exp=0/0", out_re, out_im); end
      total++; if (out_idx !== 2'd0)    begin bad++; $display("FAIL reset_out_idx got=%0d exp=0", out_idx); end
      total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (frame_cnt !== 8'd0)  begin bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
   endtask

   task automatic test_impulse();
      logic [15:0] er;
      logic [15:0] ei;
      bit tmo;
      er = 16'h1111;
      ei = 16'h0000;
      load_frame(16'h0004, 16'h0000);
      drain(tmo);
      total++;
      if (tmo) begin bad++; $display("FAIL impulse_timeout got=no out_valid exp=out_valid"); end
      else for (int k = 0; k < 4; k++) begin
         if ({got_v[k], got_idx[k], got_re[k], got_im[k]} !== {1'b1, 2'(k), er[4*k +: 4], ei[4*k +: 4]}) begin
            bad++;
            $display("FAIL impulse_y%0d got v=%b idx=%0d re=%h im=%h exp v=1 idx=%0d re=%h im=%h",
                     k, got_v[k], got_idx[k], got_re[k], got_im[k], k, er[4*k +: 4], ei[4*k +: 4]);
         end
         if (k < 3) total++;
      end
      total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL impulse_frame_cnt got=%0d exp=1", frame_cnt); end
      total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL impulse_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_bin1();
      logic [15:0] er;
      logic [15:0] ei;
      bit tmo;
      er = 16'h0F01;
      ei = 16'hF010;
      load_frame(16'h0040, 16'h0000);
      drain(tmo);
      total++;
      if (tmo) begin bad++; $display("FAIL bin1_timeout got=no out_valid exp=out_valid"); end
      else for (int k = 0; k < 4; k++) begin
         if ({got_v[k], got_idx[k], got_re[k], got_im[k]} !== {1'b1, 2'(k), er[4*k +: 4], ei[4*k +: 4]}) begin
            bad++;
            $display("FAIL bin1_y%0d got v=%b idx=%0d re=%h im=%h exp v=1 idx=%0d re=%h im=%h",
                     k, got_v[k], got_idx[k], got_re[k], got_im[k], k, er[4*k +: 4], ei[4*k +: 4]);
         end
         if (k < 3) total++;
      end
   endtask

   task automatic test_floor_extremes();
      logic [15:0] xr [3];
      logic [15:0] xi [3];
      logic [15:0] er [3];
      logic [15:0] ei [3];
      bit tmo;
      xr[0] = 16'h000F; xi[0] = 16'h0000; er[0] = 16'hFFFF; ei[0] = 16'h0000;
      xr[1] = 16'h8888; xi[1] = 16'h8888; er[1] = 16'h0008; ei[1] = 16'h0008;
      xr[2] = 16'h7777; xi[2] = 16'h7777; er[2] = 16'h0007; ei[2] = 16'h0007;
      for (int c = 0; c < 3; c++) begin
         load_frame(xr[c], xi[c]);
         drain(tmo);
         total++;
         if (tmo) begin bad++; $display("FAIL floor%0d_timeout got=no out_valid exp=out_valid", c); end
         else for (int k = 0; k < 4; k++) begin
            if ({got_v[k], got_idx[k], got_re[k], got_im[k]} !== {1'b1, 2'(k), er[c][4*k +: 4], ei[c][4*k +: 4]}) begin
               bad++;
               $display("FAIL floor%0d_y%0d got v=%b idx=%0d re=%h im=%h exp v=1 idx=%0d re=%h im=%h",
                        c, k, got_v[k], got_idx[k], got_re[k], got_im[k], k, er[c][4*k +: 4], ei[c][4*k +: 4]);
            end
            if (k < 3) total++;
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] er;
      logic [15:0] ei;
      int n;
      er = 16'h2101;
      ei = 16'h1012;
      load_frame(16'h0004, 16'h0044);
      out_ready = 1'b1;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge wb_clk_i); #1;
         n++;
      end
      total++;
      if ({out_valid, out_idx, out_re, out_im} !== {1'b1, 2'd0, er[3:0], ei[3:0]}) begin
         bad++;
         $display("FAIL bp_y0 got v=%b idx=%0d re=%h im=%h exp v=1 idx=0 re=%h im=%h",
                  out_valid, out_idx, out_re, out_im, er[3:0], ei[3:0]);
      end
      @(posedge wb_clk_i); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_re     = 4'h7;
      in_im     = 4'h7;
      for (int h = 0; h < 6; h++) begin
         total++;
         if ({out_valid, out_idx, out_re, out_im, in_ready} !== {1'b1, 2'd1, er[7:4], ei[7:4], 1'b0}) begin
            bad++;
            $display("FAIL bp_hold%0d got v=%b idx=%0d re=%h im=%h rdy=%b exp v=1 idx=1 re=%h im=%h rdy=0",
                     h, out_valid, out_idx, out_re, out_im, in_ready, er[7:4], ei[7:4]);
         end
         if (h < 5) begin @(posedge wb_clk_i); #1; end
      end
      in_valid  = 1'b0;
      in_re     = 4'h0;
      in_im     = 4'h0;
      out_ready = 1'b1;
      for (int k = 1; k < 4; k++) begin
         total++;
         if ({out_valid, out_idx, out_re, out_im} !== {1'b1, 2'(k), er[4*k +: 4], ei[4*k +: 4]}) begin
            bad++;
            $display("FAIL bp_y%0d got v=%b idx=%0d re=%h im=%h exp v=1 idx=%0d re=%h im=%h",
                     k, out_valid, out_idx, out_re, out_im, k, er[4*k +: 4], ei[4*k +: 4]);
         end
         @(posedge wb_clk_i); #1;
      end
      out_ready = 1'b0;
      total++;
      if ({in_ready, out_valid} !== 2'b10) begin
         bad++;
         $display("FAIL bp_after_y3 got in_ready=%b out_valid=%b exp in_ready=1 out_valid=0", in_ready, out_valid);
      end
   endtask

   task automatic test_gaps_latency();
      logic [15:0] er;
      bit tmo;
      er = 16'hF1F1;
      for (int c = 0; c < 8; c++) begin
         in_valid = ((c % 2) == 0);
         in_re    = (c == 4) ? 4'h4 : (((c % 2) == 1) ? 4'h7 : 4'h0);
         in_im    = ((c % 2) == 1) ? 4'h7 : 4'h0;
         @(posedge wb_clk_i); #1;
         if (c == 6) begin
            total++;
            if ({out_valid, in_ready, busy} !== 3'b001) begin
               bad++;
               $display("FAIL gap_e0 got v=%b rdy=%b busy=%b exp v=0 rdy=0 busy=1", out_valid, in_ready, busy);
            end
         end
         if (c == 7) begin
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL gap_e1 got out_valid=%b exp=0", out_valid); end
         end
      end
      in_valid = 1'b0;
      in_re    = 4'h0;
      in_im    = 4'h0;
      @(posedge wb_clk_i); #1;
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL gap_e2 got out_valid=%b exp=1", out_valid); end
      drain(tmo);
      total++;
      if (tmo) begin bad++; $display("FAIL gap_timeout got=no out_valid exp=out_valid"); end
      else for (int k = 0; k < 4; k++) begin
         if ({got_v[k], got_idx[k], got_re[k], got_im[k]} !== {1'b1, 2'(k), er[4*k +: 4], 4'h0}) begin
            bad++;
            $display("FAIL gap_y%0d got v=%b idx=%0d re=%h im=%h exp v=1 idx=%0d re=%h im=0",
                     k, got_v[k], got_idx[k], got_re[k], got_im[k], k, er[4*k +: 4]);
         end
         if (k < 3) total++;
      end
      total++; if (frame_cnt !== 8'd7) begin bad++; $display("FAIL gap_frame_cnt got=%0d exp=7", frame_cnt); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] er;
      bit tmo;
      er = 16'h1111;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_re    = 4'h7;
         in_im    = 4'h3;
         @(posedge wb_clk_i); #1;
      end
      in_valid = 1'b0;
      wb_rst_i = 1'b1;
      @(posedge wb_clk_i); #1;
      wb_rst_i = 1'b0;
      total++;
      if ({in_ready, out_valid, out_re, out_im, out_idx, busy, frame_cnt} !== {1'b1, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 8'd0}) begin
         bad++;
         $display("FAIL midrst_state got rdy=%b v=%b re=%h im=%h idx=%0d busy=%b fc=%0d exp rdy=1 v=0 re=0 im=0 idx=0 busy=0 fc=0",
                  in_ready, out_valid, out_re, out_im, out_idx, busy, frame_cnt);
      end
      load_frame(16'h0004, 16'h0000);
      drain(tmo);
      total++;
      if (tmo) begin bad++; $display("FAIL midrst_timeout got=no out_valid exp=out_valid"); end
      else for (int k = 0; k < 4; k++) begin
         if ({got_v[k], got_idx[k], got_re[k], got_im[k]} !== {1'b1, 2'(k), er[4*k +: 4], 4'h0}) begin
            bad++;
            $display("FAIL midrst_y%0d got v=%b idx=%0d re=%h im=%h exp v=1 idx=%0d re=%h im=0",
                     k, got_v[k], got_idx[k], got_re[k], got_im[k], k, er[4*k +: 4]);
         end
         if (k < 3) total++;
      end
      total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL midrst_frame_cnt got=%0d exp=1", frame_cnt); end
   endtask

   task automatic test_wrap();
      bit tmo;
      bit dead;
      dead = 1'b0;
      for (int f = 0; f < 254 && !dead; f++) begin
         load_frame(16'h0000, 16'h0000);
         drain(tmo);
         if (tmo) dead = 1'b1;
      end
      total++;
      if (dead) begin bad++; $display("FAIL wrap_timeout got=no out_valid exp=out_valid"); end
      else begin
         total++;
         if (frame_cnt !== 8'd255) begin bad++; $display("FAIL wrap_pre got=%0d exp=255", frame_cnt); end
         load_frame(16'h0000, 16'h0000);
         drain(tmo);
         if (tmo || frame_cnt !== 8'd0) begin
            bad++;
            $display("FAIL wrap_zero got=%0d tmo=%b exp=0 tmo=0", frame_cnt, tmo);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_impulse();
      test_bin1();
      test_floor_extremes();
      test_backpressure();
      test_gaps_latency();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
